bird_motion: RTL
================

// Module: bird_motion
// PURPOSE
// - Bird vertical-motion engine; sits directly upstream of the game-over/score
//   checker and drives its playerPosition input.
// - Converts flap presses and a frame tick into a one-hot row vector.
// - Applies gravity (one row down every FALL_TICKS ticks) and lift
//   (RISE_ROWS rows up per flap).
// - Freezes the bird when over is asserted; returns to the start row when
//   start drops.
// PARAMETERS
// - ROWS         8  number of playfield rows; bit 0 = floor row, bit ROWS-1 = top row
// - START_ROW    4  row index loaded on reset / idle
// - FALL_TICKS   2  ticks per one-row drop (>=1)
// - RISE_ROWS    2  rows gained per flap (>=1)
// - REPEAT_TICKS 3  autorepeat period in ticks (used only with BIRD_AUTOREPEAT_EN)
// PORTS
// - clk            in   1                  clock
// - reset          in   1                  synchronous, active-high reset
// - start          in   1                  game enable; low = idle
// - over           in   1                  registered game-over flag from the checker
// - tick           in   1                  one-cycle frame pulse
// - key            in   1                  flap button; level, already synchronised to clk
// - playerPosition out  ROWS               one-hot bird row, registered
// - row_idx        out  $clog2(ROWS)       binary bird row, registered
// - flying         out  1                  high while in FLY
// BEHAVIOUR
// - Reset (clk = clk, reset = reset: synchronous, active-high) forces:
//   - state = IDLE, row_idx = START_ROW, playerPosition = 1<<START_ROW, flying = 0
//   - fall_cnt = 0, flap_pend = 0, key_q = 0
// - Flap detect:
//   - key_q registers key every cycle; edge = key & ~key_q
//   - edge sets flap_pend; flap_pend clears on the tick that consumes it
//   - edge and tick in the same cycle: the flap counts for that tick
//   - N>1 edges between ticks collapse to one flap
// - FSM states: IDLE, FLY, DEAD. Transition priority: reset > !start > over > tick.
//   - IDLE: hold START_ROW; flap_pend held at 0.
//     - start=1 -> FLY next cycle; row unchanged.
//   - FLY: on tick=1:
//     - flap (flap_pend | edge): row = min(row+RISE_ROWS, ROWS-1); fall_cnt = 0
//     - else if fall_cnt == FALL_TICKS-1: row = max(row-1, 0); fall_cnt = 0
//     - else: fall_cnt++
//     - no tick: row and fall_cnt hold
//     - over=1 -> DEAD; takes priority over a same-cycle tick, so no row update
//   - DEAD: row frozen; key, tick and flap_pend ignored; flap_pend held at 0.
//     - start=0 -> IDLE (reloads START_ROW); over deasserting alone does not leave DEAD
//   - start=0 in any state -> IDLE next cycle; reload START_ROW; clear fall_cnt and flap_pend.
// - Arithmetic and latency:
//   - row math in $clog2(ROWS)+1 bits, then saturated; no wrap at the top or floor
//   - row 0 is legal and held; floor detection belongs downstream
//   - playerPosition and row_idx update on the edge that samples tick=1 (latency 1 clk)
//   - invariant: playerPosition == 1<<row_idx, exactly one bit set at all times
// CONFIGURATION
// - Macro BIRD_AUTOREPEAT_EN.
// - Defined:
//   - while key stays high in FLY, a repeat counter counts ticks
//   - every REPEAT_TICKS-th tick with key still high generates a flap
//   - counter clears on key low, on any edge, and on leaving FLY
// - Undefined: only rising edges flap; no repeat counter is synthesised.
// TESTING (ROWS=8, START_ROW=4, FALL_TICKS=2, RISE_ROWS=2, macro off unless stated)
// - reset=1 for 2 clks -> playerPosition=8'b0001_0000, row_idx=4, flying=0
// - start=1, key=0, 4 ticks -> rows 4,3,3,2 after ticks 1..4 (8'b0000_0100 at end)
// - row 2, key edge 5 clks before tick -> row 4 after tick; fall_cnt=0, so the next
//   drop needs 2 more ticks
// - row 6, flap -> row 7 (8'b1000_0000); flap again -> stays 7
// - 3 key edges between ticks, plus an edge coincident with the tick -> exactly +2 rows
// - fall to row 0, 3 more ticks -> stays 8'b0000_0001; over=1 -> flying=0, key/tick
//   ignored; start=0 -> row 4
// - BIRD_AUTOREPEAT_EN, key held high from row 2 over 7 ticks -> flaps on edge-tick
//   and ticks 3 and 6

Source files
------------

// File: rtl/bird_motion.sv
// Bird vertical-motion engine: flap/gravity row tracking driving the checker's playerPosition.
// Latency: row_idx/playerPosition update on the clk edge that samples tick=1 (1 clk).
// No backpressure: tick/key are consumed every cycle; optional BIRD_AUTOREPEAT_EN adds held-key repeat flaps.
module bird_motion #(
    parameter int ROWS         = 8,
    parameter int START_ROW    = 4,
    parameter int FALL_TICKS   = 2,
    parameter int RISE_ROWS    = 2,
    parameter int REPEAT_TICKS = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    over,
    input  logic                    tick,
    input  logic                    key,
    output logic [ROWS-1:0]         playerPosition,
    output logic [$clog2(ROWS)-1:0] row_idx,
    output logic                    flying
);

    localparam int RW = $clog2(ROWS);
    localparam int FW = (FALL_TICKS > 1) ? $clog2(FALL_TICKS) : 1;

    localparam logic [RW:0]     RISE_W    = (RW+1)'(RISE_ROWS);
    localparam logic [RW:0]     TOP_W     = (RW+1)'(ROWS-1);
    localparam logic [RW-1:0]   START_W   = RW'(START_ROW);
    localparam logic [RW-1:0]   ONE_R     = 1;
    localparam logic [FW-1:0]   FALL_LAST = FW'(FALL_TICKS-1);
    localparam logic [FW-1:0]   ONE_F     = 1;
    localparam logic [ROWS-1:0] ONE_P     = 1;

    typedef enum logic [1:0] {IDLE, FLY, DEAD} state_t;

    state_t          state, state_n;
    logic [RW-1:0]   row_n;
    logic [FW-1:0]   fall_cnt, fall_n;
    logic            flap_pend, pend_n;
    logic            key_q;
    logic            key_edge;
    logic            flap_now;
    logic [RW:0]     row_up;

`ifdef BIRD_AUTOREPEAT_EN
    localparam int RPW = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;
    localparam logic [RPW-1:0] REP_LAST = RPW'(REPEAT_TICKS-1);
    localparam logic [RPW-1:0] ONE_RP   = 1;
    logic [RPW-1:0]  rep_cnt, rep_n;
    logic            rep_flap;
`else
    // Repeat period only matters when autorepeat is built in.
    localparam int unused_repeat_ticks = REPEAT_TICKS;
`endif

    assign key_edge = key & ~key_q;
    assign row_up   = {1'b0, row_idx} + RISE_W;
    assign flying   = (state == FLY);

    // Next-state, next-row and flap bookkeeping; priority is !start > over > tick.
    always_comb begin
        state_n  = state;
        row_n    = row_idx;
        fall_n   = fall_cnt;
        pend_n   = flap_pend;
        flap_now = 1'b0;
`ifdef BIRD_AUTOREPEAT_EN
        rep_n    = rep_cnt;
        rep_flap = 1'b0;
`endif
        if (!start) begin
            state_n = IDLE;
            row_n   = START_W;
            fall_n  = '0;
            pend_n  = 1'b0;
`ifdef BIRD_AUTOREPEAT_EN
            rep_n   = '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    state_n = FLY;
                    pend_n  = 1'b0;
`ifdef BIRD_AUTOREPEAT_EN
                    rep_n   = '0;
`endif
                end
                FLY: begin
                    if (over) begin
                        // Game over freezes the row, even against a same-cycle tick.
                        state_n = DEAD;
                        pend_n  = 1'b0;
`ifdef BIRD_AUTOREPEAT_EN
                        rep_n   = '0;
`endif
                    end else begin
`ifdef BIRD_AUTOREPEAT_EN
                        if (!key || key_edge) begin
                            rep_n = '0;
                        end else if (tick) begin
                            if (rep_cnt == REP_LAST) begin
                                rep_flap = 1'b1;
                                rep_n    = '0;
                            end else begin
                                rep_n = rep_cnt + ONE_RP;
                            end
                        end
                        flap_now = flap_pend | key_edge | rep_flap;
`else
                        flap_now = flap_pend | key_edge;
`endif
                        if (tick) begin
                            pend_n = 1'b0;
                            if (flap_now) begin
                                row_n  = (row_up > TOP_W) ? TOP_W[RW-1:0] : row_up[RW-1:0];
                                fall_n = '0;
                            end else if (fall_cnt == FALL_LAST) begin
                                row_n  = (row_idx != '0) ? (row_idx - ONE_R) : row_idx;
                                fall_n = '0;
                            end else begin
                                fall_n = fall_cnt + ONE_F;
                            end
                        end else if (key_edge) begin
                            // Several edges between ticks collapse into one pending flap.
                            pend_n = 1'b1;
                        end
                    end
                end
                DEAD: begin
                    pend_n = 1'b0;
                end
                default: begin
                    state_n = IDLE;
                    row_n   = START_W;
                    fall_n  = '0;
                    pend_n  = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers; playerPosition is re-decoded from the next row.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            row_idx        <= START_W;
            playerPosition <= ONE_P << START_W;
            fall_cnt       <= '0;
            flap_pend      <= 1'b0;
            key_q          <= 1'b0;
`ifdef BIRD_AUTOREPEAT_EN
            rep_cnt        <= '0;
`endif
        end else begin
            state          <= state_n;
            row_idx        <= row_n;
            playerPosition <= ONE_P << row_n;
            fall_cnt       <= fall_n;
            flap_pend      <= pend_n;
            key_q          <= key;
`ifdef BIRD_AUTOREPEAT_EN
            rep_cnt        <= rep_n;
`endif
        end
    end

endmodule
